// File: rtl/pid_controller_mc.sv
// Time-multiplexed multi-channel PID controller; one datapath shared by NCH loops.
// Define PID_ANTIWINDUP_EN to clamp the integral state to [-I_LIM, +I_LIM].
module pid_controller_mc #(
  parameter int DATA_W  = 32,
  parameter int NCH     = 4,
  parameter int KP      = 18,
  parameter int KI      = 10,
  parameter int KD      = 10,
  parameter int DIV     = 264,
  parameter int OUT_MIN = -10,
  parameter int OUT_MAX = 10,
  parameter int I_LIM   = 1000,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     err_valid,
  output logic                     err_ready,
  input  logic [CH_W-1:0]          err_ch,
  input  logic signed [DATA_W-1:0] err,
  input  logic                     clr_valid,
  input  logic [CH_W-1:0]          clr_ch,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [DATA_W-1:0] out
);

  localparam int AW = 2 * DATA_W;

`ifdef PID_ANTIWINDUP_EN
  localparam bit AW_EN = 1'b1;
`else
  localparam bit AW_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SUM, S_OUT} state_t;

  state_t                   state;
  logic [CH_W-1:0]          ch_q;
  logic signed [DATA_W-1:0] e_q;
  logic signed [DATA_W-1:0] i_q;
  logic signed [AW-1:0]     p_q;
  logic signed [AW-1:0]     d_q;
  logic signed [DATA_W-1:0] integ [NCH];
  logic signed [DATA_W-1:0] prev  [NCH];

  logic signed [DATA_W:0]   i_wide;
  logic signed [DATA_W:0]   i_pos;
  logic signed [DATA_W:0]   i_neg;
  logic signed [DATA_W-1:0] i_new;
  logic signed [AW-1:0]     s_sum;
  logic signed [AW-1:0]     q_div;
  logic signed [DATA_W-1:0] q_sat;

  function automatic logic ch_ok(input logic [CH_W-1:0] c);
    return int'(c) < NCH;
  endfunction

  assign err_ready = (state == S_IDLE);

  always_comb begin
    // integral sum is one bit wider so the anti-windup clamp sees the true value
    i_wide = (DATA_W+1)'(integ[ch_q]) + (DATA_W+1)'(e_q);
    i_pos  = (DATA_W+1)'(I_LIM);
    i_neg  = -i_pos;
    i_new  = i_wide[DATA_W-1:0];
    if (AW_EN) begin
      if (i_wide > i_pos)
        i_new = i_pos[DATA_W-1:0];
      else if (i_wide < i_neg)
        i_new = i_neg[DATA_W-1:0];
    end
    s_sum = p_q + AW'(KI) * AW'(i_q) + AW'(KD) * d_q;
    q_div = s_sum / AW'(DIV);
    if (q_div > AW'(OUT_MAX))
      q_sat = DATA_W'(OUT_MAX);
    else if (q_div < AW'(OUT_MIN))
      q_sat = DATA_W'(OUT_MIN);
    else
      q_sat = q_div[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ch_q      <= '0;
      e_q       <= '0;
      i_q       <= '0;
      p_q       <= '0;
      d_q       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out       <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        integ[k[CH_W-1:0]] <= '0;
        prev[k[CH_W-1:0]]  <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (err_valid && ch_ok(err_ch)) begin
            e_q   <= err;
            ch_q  <= err_ch;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          p_q          <= AW'(KP) * AW'(e_q);
          d_q          <= AW'(e_q) - AW'(prev[ch_q]);
          i_q          <= i_new;
          integ[ch_q]  <= i_new;
          prev[ch_q]   <= e_q;
          state        <= S_SUM;
        end
        S_SUM: begin
          out       <= q_sat;
          out_ch    <= ch_q;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // placed after the write-back so a same-channel clear takes priority
      if (clr_valid && ch_ok(clr_ch)) begin
        integ[clr_ch] <= '0;
        prev[clr_ch]  <= '0;
      end
    end
  end

endmodule

// File: doc/pid_controller_mc.md
# pid_controller_mc

Multi-channel, time-multiplexed PID controller with parametrised data width, channel count, gains and output range. It generalises the single-loop PID used in the motor-control path: per-channel integral and previous-error state, a valid/ready input handshake, a tagged output strobe, integral anti-windup and per-channel clear. One arithmetic datapath serves all NCH loops, so several actuators share a single instance.

## Interface
- DATA_W, 32: width of error, integral, previous-error and output (signed two's complement)
- NCH, 4: number of independent channels (≥1); CH_W = max(1, $clog2(NCH))
- KP, 18: proportional gain (signed integer)
- KI, 10: integral gain
- KD, 10: derivative gain
- DIV, 264: post-sum divisor (>0)
- OUT_MIN, -10: output lower saturation bound
- OUT_MAX, 10: output upper saturation bound
- I_LIM, 1000: integral magnitude limit (anti-windup build only)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- err_valid  in  1  error sample valid
- err_ready  out  1  block can accept a sample
- err_ch  in  CH_W  channel of the sample
- err  in  DATA_W  signed error
- clr_valid  in  1  clear request
- clr_ch  in  CH_W  channel to clear
- out_valid  out  1  one-cycle result strobe
- out_ch  out  CH_W  channel of the result
- out  out  DATA_W  saturated controller output

## Operation
- FSM: IDLE → CALC → SUM → OUT → IDLE. err_ready = 1 only in IDLE.
- IDLE: on err_valid && err_ready, latch err and err_ch; go to CALC. If err_ch ≥ NCH, the sample is accepted and discarded: FSM stays in IDLE, no state change, no out_valid.
- CALC: P = KP·e; I_new = I[ch] + e; D = e − prev[ch]; write back I[ch] ← I_new, prev[ch] ← e.
- SUM: S = P + KI·I_new + KD·D, evaluated at 2·DATA_W bits (no intermediate overflow); Q = S / DIV, signed, truncated toward zero.
- OUT: out = clamp(Q, OUT_MIN, OUT_MAX); out_ch = latched ch; out_valid = 1 for exactly this cycle. out and out_ch hold until the next result.
- Clear: clr_valid with clr_ch < NCH zeroes I[clr_ch] and prev[clr_ch] at the end of that cycle, in any FSM state. If it coincides with the CALC write-back for the same channel, clear wins. The in-flight result still uses pre-clear values. clr_ch ≥ NCH is ignored.
- A clear and an accept on the same channel in the same IDLE cycle: the sample is computed with I = 0 and prev = 0.
- Channels are fully independent; no state is shared except the datapath.

## Timing
- Reset (asynchronous, rst_n = 0): FSM = IDLE, err_ready = 1, out_valid = 0, out = 0, out_ch = 0, all I[] and prev[] = 0. Reset asserted mid-operation aborts the in-flight sample; no out_valid follows.
- Latency: accept on edge N → out_valid high in cycle N+3.
- Throughput: one sample per 4 cycles. err_ready is low for the 3 cycles after an accept.
- No output backpressure: the consumer must take out on the out_valid cycle.

## Configuration
- PID_ANTIWINDUP_EN defined: I_new is clamped to [−I_LIM, +I_LIM] before write-back and use.
- Not defined: I_new is a plain DATA_W two's-complement sum (wraps on overflow), and I_LIM is unused.

## Test plan
- Reset, then ch0 err = 10 → out_valid 3 cycles after accept: out = 1 (P 180 + I 100 + D 100 = 380, /264 = 1), out_ch = 0. Repeat err = 10 on ch0 → 180 + 200 + 0 = 380 → out = 1.
- ch0 err = 100 from reset → S = 3800, Q = 14 → out = 10. ch1 err = −5 from reset → S = −190, Q = 0 (truncated toward zero) → out = 0. ch2 err = −100 → out = −10.
- Channel independence: ch0 err = 10 twice, then ch3 err = 10 → ch3 out = 1 and ch3 I = 10, unaffected by ch0 history. Back-to-back err_valid → err_ready low 3 cycles, no sample lost or duplicated.
- Anti-windup (I_LIM = 50): ch0 err = 40, 40, 0 → third out = 0 with the macro defined (I = 50: 500 − 400 = 100 → 0); out = 1 without the macro (I = 80: 800 − 400 = 400 → 1).
- Clear: after ch0 err = 40, 40, clear ch0 in the same cycle as an accept of ch0 err = 0 → out = 0, and ch0 I = 0, prev = 0. clr_ch = 7 with NCH = 4 → no effect.
- err_ch = 5 (NCH = 4) → accepted, no out_valid. rst_n pulsed while in SUM → no out_valid; out = 0, err_ready = 1 after reset.
